// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   PC_W      : width of the program counter and instruction word
//   OP_*      : primary opcodes (instr[31:26]) the fetch stage resolves itself
//   NOP_WORD  : word loaded into IF/ID when the slot is squashed
//   pc_sel_e  : next-PC source chosen each cycle
package if_stage_pkg;

    localparam int PC_W = 32;

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    localparam logic [PC_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_HOLD   = 2'd3
    } pc_sel_e;

    // Unconditional control transfers (target from the 26-bit index field).
    function automatic logic is_jump_op(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register.
//   clk_i, reset_i       : clock, asynchronous active-high reset
//   hold_i               : keep current contents (takes precedence over clear_i)
//   clear_i              : squash the slot (NOP, pc_plus4 = 0, valid = 0)
//   instr_i, pc_plus4_i  : fetched word and its fall-through address
//   instr_o, pc_plus4_o, valid_o : registered slot contents
module if_id_reg
    import if_stage_pkg::*;
(
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            hold_i,
    input  logic            clear_i,
    input  logic [PC_W-1:0] instr_i,
    input  logic [PC_W-1:0] pc_plus4_i,
    output logic [PC_W-1:0] instr_o,
    output logic [PC_W-1:0] pc_plus4_o,
    output logic            valid_o
);

    logic [PC_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0] pc_plus4_q, pc_plus4_d;
    logic            valid_q, valid_d;

    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (!hold_i) begin
            if (clear_i) begin
                instr_d    = NOP_WORD;
                pc_plus4_d = '0;
                valid_d    = 1'b0;
            end else begin
                instr_d    = instr_i;
                pc_plus4_d = pc_plus4_i;
                valid_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            instr_q    <= NOP_WORD;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage with branch/jump resolution in ID.
//   clk, reset      : clock, asynchronous active-high reset (PC <- RESET_PC)
//   stall           : freeze PC and IF/ID
//   equal           : rs == rt comparison for the instruction in ID
//   imem_rdata      : instruction word at imem_addr (combinational memory)
//   imem_addr       : current PC
//   instr_id, pc_plus4_id, valid_id : IF/ID slot
//   redirect        : taken branch or jump in ID this cycle
// Next-PC priority: stall > redirect > sequential. A redirect squashes the
// single instruction fetched down the fall-through path; no delay slot.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            equal,
    input  logic [PC_W-1:0] imem_rdata,
    output logic [PC_W-1:0] imem_addr,
    output logic [PC_W-1:0] instr_id,
    output logic [PC_W-1:0] pc_plus4_id,
    output logic            valid_id,
    output logic            redirect
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_plus4_f;
    logic [PC_W-1:0] branch_target;
    logic [PC_W-1:0] jump_target;
    logic [5:0]      opcode;
    logic            jump_taken;
    logic            branch_taken;
    pc_sel_e         pc_sel;

    always_comb begin
        opcode       = instr_id[31:26];
        jump_taken   = is_jump_op(opcode);
        branch_taken = ((opcode == OP_BEQ) &&  equal) ||
                       ((opcode == OP_BNE) && !equal);
        // A squashed slot may still carry stale opcode bits in principle;
        // valid_id gates it so only real instructions redirect.
        redirect     = valid_id && (jump_taken || branch_taken);

        pc_plus4_f    = pc_q + 32'd4;
        branch_target = pc_plus4_id + {{14{instr_id[15]}}, instr_id[15:0], 2'b00};
        jump_target   = {pc_plus4_id[31:28], instr_id[25:0], 2'b00};

        if (stall) begin
            pc_sel = PC_HOLD;
        end else if (redirect) begin
            pc_sel = jump_taken ? PC_JUMP : PC_BRANCH;
        end else begin
            pc_sel = PC_SEQ;
        end

        case (pc_sel)
            PC_HOLD:   pc_d = pc_q;
            PC_BRANCH: pc_d = branch_target;
            PC_JUMP:   pc_d = jump_target;
            default:   pc_d = pc_plus4_f;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign imem_addr = pc_q;

    // Hold wins over clear inside the register, so a redirect seen during
    // a stall is simply re-evaluated on the first free edge.
    if_id_reg u_if_id (
        .clk_i      (clk),
        .reset_i    (reset),
        .hold_i     (stall),
        .clear_i    (redirect),
        .instr_i    (imem_rdata),
        .pc_plus4_i (pc_plus4_f),
        .instr_o    (instr_id),
        .pc_plus4_o (pc_plus4_id),
        .valid_o    (valid_id)
    );

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    localparam logic [31:0] BASE    = 32'h0040_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;
    localparam logic [31:0] W_WORD  = 32'h2108_0001;  // non-control opcode
    localparam logic [31:0] BEQ3    = 32'h1043_0003;
    localparam logic [31:0] BNE3    = 32'h1443_0003;
    localparam logic [31:0] BEQM1   = 32'h1043_FFFF;
    localparam logic [31:0] J_W     = 32'h0810_0000;
    localparam logic [31:0] JAL_W   = 32'h0C10_0004;

    // ---------------- clock / reset / signals ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        equal = 1'b0;
    logic [31:0] imem_rdata, imem_addr, instr_id, pc_plus4_id;
    logic        valid_id, redirect;
    logic [31:0] imem_addr_w, instr_id_w, pc_plus4_id_w;
    logic        valid_id_w, redirect_w;
    logic [31:0] imem_rdata_w;
    logic [31:0] mem [0:63];
    logic [31:0] mem_off;

    int n_vec  = 0;
    int n_miss = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    assign mem_off      = imem_addr - BASE;
    assign imem_rdata_w = W_WORD;

    always_comb begin
        imem_rdata = 32'h0;
        if (mem_off < 32'd256) imem_rdata = mem[mem_off[7:2]];
    end

    if_stage #(.RESET_PC(BASE)) dut (
        .clk(clk), .reset(reset), .stall(stall), .equal(equal),
        .imem_rdata(imem_rdata), .imem_addr(imem_addr), .instr_id(instr_id),
        .pc_plus4_id(pc_plus4_id), .valid_id(valid_id), .redirect(redirect)
    );

    if_stage #(.RESET_PC(WRAP_PC)) dut_w (
        .clk(clk), .reset(reset), .stall(stall), .equal(equal),
        .imem_rdata(imem_rdata_w), .imem_addr(imem_addr_w), .instr_id(instr_id_w),
        .pc_plus4_id(pc_plus4_id_w), .valid_id(valid_id_w), .redirect(redirect_w)
    );

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_instr, m_pp4;
    logic        m_valid;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (off < 32'd256) return mem[off / 4];
        return 32'h0;
    endfunction

    function automatic logic m_taken(input logic [31:0] ins, input logic v, input logic eq);
        int op;
        op = int'(ins / 32'h0400_0000);
        if (!v) return 1'b0;
        if (op == 2 || op == 3) return 1'b1;
        if (op == 4) return eq;
        if (op == 5) return !eq;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] ins, input logic [31:0] pp4);
        int op;
        int off;
        op = int'(ins / 32'h0400_0000);
        if (op == 2 || op == 3)
            return (pp4 & 32'hF000_0000) + ((ins % 32'h0400_0000) * 4);
        off = int'($signed(ins[15:0]));
        return pp4 + 32'(off * 4);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc = BASE; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
        end else if (!stall) begin
            if (m_taken(m_instr, m_valid, equal)) begin
                m_pc    = m_target(m_instr, m_pp4);
                m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
            end else begin
                m_instr = mem_rd(m_pc);
                m_pp4   = m_pc + 32'd4;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #3;
        check("m_imem_addr", imem_addr, m_pc);
        check("m_instr_id", instr_id, m_instr);
        check("m_pc_plus4_id", pc_plus4_id, m_pp4);
        check("m_valid_id", {31'h0, valid_id}, {31'h0, m_valid});
        check("m_redirect", {31'h0, redirect}, {31'h0, m_taken(m_instr, m_valid, equal)});
        check("no_x", {31'h0, $isunknown({imem_addr, instr_id, pc_plus4_id, valid_id, redirect,
                                          imem_addr_w, instr_id_w, pc_plus4_id_w, valid_id_w,
                                          redirect_w})}, 32'h0);
        check("w_redirect", {31'h0, redirect_w}, 32'h0);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #4;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_addr", imem_addr, BASE);
        check("rst_instr", instr_id, 32'h0);
        check("rst_pp4", pc_plus4_id, 32'h0);
        check("rst_valid", {31'h0, valid_id}, 32'h0);
        check("rst_redirect", {31'h0, redirect}, 32'h0);
        check("rst_addr_w", imem_addr_w, WRAP_PC);
        repeat (2) @(posedge clk);
        #4;
        reset = 1'b0;
    endtask

    task automatic run_addr_trace();
        while (exp_q.size() > 0) begin
            tick();
            check("pc_trace", imem_addr, exp_q.pop_front());
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        clear_mem();
        #2;

        // Sequential fetch from RESET_PC over NOP memory; wrap instance.
        do_reset();
        tick();
        check("s1_addr", imem_addr, 32'h0040_0004);
        check("s1_valid", {31'h0, valid_id}, 32'h1);
        check("s1_pp4", pc_plus4_id, 32'h0040_0004);
        check("wrap_addr", imem_addr_w, 32'h0000_0000);
        check("wrap_pp4", pc_plus4_id_w, 32'h0000_0000);
        check("wrap_valid", {31'h0, valid_id_w}, 32'h1);
        check("wrap_instr", instr_id_w, W_WORD);
        exp_q.push_back(32'h0040_0008);
        exp_q.push_back(32'h0040_000C);
        run_addr_trace();

        // Taken BEQ, imm 3, at 0x00400004.
        mem[1] = BEQ3; equal = 1'b1;
        do_reset();
        tick(); tick();
        check("beq_redirect", {31'h0, redirect}, 32'h1);
        check("beq_pp4", pc_plus4_id, 32'h0040_0008);
        tick();
        check("beq_target", imem_addr, 32'h0040_0014);
        check("beq_squash", {31'h0, valid_id}, 32'h0);
        check("beq_nop", instr_id, 32'h0);
        tick();
        check("beq_refill", {31'h0, valid_id}, 32'h1);
        check("beq_refill_pp4", pc_plus4_id, 32'h0040_0018);

        // BEQ not taken, then BNE not taken.
        equal = 1'b0;
        do_reset();
        tick(); tick();
        check("beq_nt_redirect", {31'h0, redirect}, 32'h0);
        tick();
        check("beq_nt_addr", imem_addr, 32'h0040_000C);
        mem[1] = BNE3; equal = 1'b1;
        do_reset();
        tick(); tick();
        check("bne_nt_redirect", {31'h0, redirect}, 32'h0);
        equal = 1'b0;
        #1;
        check("bne_t_redirect", {31'h0, redirect}, 32'h1);
        equal = 1'b1;
        tick();
        check("bne_nt_addr", imem_addr, 32'h0040_000C);

        // Backward branch to itself.
        clear_mem();
        mem[3] = BEQM1; equal = 1'b1;
        do_reset();
        repeat (4) tick();
        check("back_pp4", pc_plus4_id, 32'h0040_0010);
        check("back_redirect", {31'h0, redirect}, 32'h1);
        tick();
        check("back_target", imem_addr, 32'h0040_000C);
        tick();
        check("back_refetch", instr_id, BEQM1);
        equal = 1'b0;
        tick();
        check("back_exit", imem_addr, 32'h0040_0014);

        // J with a branch on the fall-through path, then JAL.
        clear_mem();
        mem[0] = J_W; mem[1] = BEQ3; equal = 1'b1;
        do_reset();
        tick();
        check("j_pp4", pc_plus4_id, 32'h0040_0004);
        check("j_redirect", {31'h0, redirect}, 32'h1);
        tick();
        check("j_target", imem_addr, 32'h0040_0000);
        check("j_ft_valid", {31'h0, valid_id}, 32'h0);
        check("j_ft_redirect", {31'h0, redirect}, 32'h0);
        mem[0] = JAL_W;
        do_reset();
        tick(); tick();
        check("jal_target", imem_addr, 32'h0040_0010);

        // Stall held two edges with BEQ in ID and equal toggling.
        clear_mem();
        mem[1] = BEQ3; equal = 1'b0;
        do_reset();
        tick(); tick();
        stall = 1'b1;
        tick();
        check("stall_addr1", imem_addr, 32'h0040_0008);
        check("stall_instr1", instr_id, BEQ3);
        equal = 1'b1;
        #1;
        check("stall_redirect", {31'h0, redirect}, 32'h1);
        tick();
        check("stall_addr2", imem_addr, 32'h0040_0008);
        check("stall_pp42", pc_plus4_id, 32'h0040_0008);
        equal = 1'b0; #1; equal = 1'b1;
        stall = 1'b0;
        tick();
        check("release_target", imem_addr, 32'h0040_0014);
        check("release_squash", {31'h0, valid_id}, 32'h0);

        // Reset pulse while a redirect is pending.
        do_reset();
        tick(); tick();
        check("pre_rst_redirect", {31'h0, redirect}, 32'h1);
        do_reset();
        tick();
        check("post_rst_addr", imem_addr, 32'h0040_0004);
        check("post_rst_pp4", pc_plus4_id, 32'h0040_0004);
        check("post_rst_valid", {31'h0, valid_id}, 32'h1);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
